// File: rtl/viterbi_decoder_pkg.sv
// Shared constants, types and helpers for the K=4, rate-1/2 Viterbi decoder.
// Build option: VITERBI_NORM_EN selects 6-bit normalised path metrics;
// when undefined, metrics are 12-bit saturating with no normalisation.
package viterbi_decoder_pkg;

  localparam int NUM_STATES = 8;
  localparam int TB_DEPTH   = 15;

  // Generator masks applied to {u, s2, s1, s0}.
  localparam logic [3:0] G0_MASK = 4'b1111;
  localparam logic [3:0] G1_MASK = 4'b1101;

  localparam int PM_INIT = 16;

`ifdef VITERBI_NORM_EN
  localparam int PM_W = 6;
`else
  localparam int PM_W = 12;
`endif

  localparam int PM_MAX = (1 << PM_W) - 1;

  typedef logic [2:0]      state_t;
  typedef logic [PM_W-1:0] metric_t;
  typedef logic [1:0]      bm_t;

  // Encoder output {c0, c1} for input bit u leaving state s.
  function automatic logic [1:0] enc_out(input logic u, input state_t s);
    logic [3:0] r;
    r = {u, s};
    return {^(r & G0_MASK), ^(r & G1_MASK)};
  endfunction

  // Hamming distance between two 2-bit symbols.
  function automatic bm_t hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return bm_t'(x[0]) + bm_t'(x[1]);
  endfunction

  // Metric plus branch metric, clamped at the largest representable metric.
  function automatic metric_t sat_add(input metric_t a, input bm_t b);
    logic [PM_W:0] s;
    s = {1'b0, a} + (PM_W+1)'(b);
    if (s > (PM_W+1)'(PM_MAX)) begin
      return metric_t'(PM_MAX);
    end
    return s[PM_W-1:0];
  endfunction

endpackage

// File: rtl/viterbi_decoder_acs.sv
// Add-compare-select cell for one next state.
// Metric width follows VITERBI_NORM_EN through the shared package.
// Candidate 0 comes from the predecessor ending in 0; it wins ties.
module viterbi_acs
  import viterbi_decoder_pkg::*;
(
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [1:0]      bm0_i,
  input  logic [1:0]      bm1_i,
  output logic [PM_W-1:0] pm_o,
  output logic            dec_o
);

  metric_t cand0;
  metric_t cand1;

  // Add both branches, keep the strictly smaller one (ties go to predecessor 0).
  always_comb begin
    cand0 = sat_add(pm0_i, bm0_i);
    cand1 = sat_add(pm1_i, bm1_i);
    dec_o = (cand1 < cand0);
    pm_o  = dec_o ? cand1 : cand0;
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder, K=4, rate 1/2, generators 1111/1101.
// Register-exchange survivors, 15 symbols deep, continuous decoding.
// Build option: VITERBI_NORM_EN subtracts the minimum new metric after
// every ACS step (6-bit metrics); otherwise 12-bit saturating metrics.
// Handshake: a symbol on Rx is consumed on every rising edge of clock
// where seqrdy=1 and reset=0; oen=1 marks Dx as a valid decoded bit,
// and both outputs hold while seqrdy=0.
module viterbi_decoder
  import viterbi_decoder_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] Rx,
  input  logic       seqrdy,
  output logic       Dx,
  output logic       oen
);

  metric_t             pm_q   [NUM_STATES];
  metric_t             pm_d   [NUM_STATES];
  logic [TB_DEPTH-1:0] path_q [NUM_STATES];
  logic [TB_DEPTH-1:0] path_d [NUM_STATES];
  logic [3:0]          cnt_q;
  logic [3:0]          cnt_d;

  bm_t                 bm0    [NUM_STATES];
  bm_t                 bm1    [NUM_STATES];
  metric_t             acs_pm [NUM_STATES];
  logic                acs_dec[NUM_STATES];

  state_t              min_state;

  // Branch metrics for both transitions into each next state.
  always_comb begin
    for (int i = 0; i < NUM_STATES; i++) begin
      state_t ns;
      state_t p0;
      state_t p1;
      ns     = state_t'(i);
      p0     = {ns[1:0], 1'b0};
      p1     = {ns[1:0], 1'b1};
      bm0[i] = hamming2(Rx, enc_out(ns[2], p0));
      bm1[i] = hamming2(Rx, enc_out(ns[2], p1));
    end
  end

  // One ACS cell per next state, fed from its two predecessors.
  for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
    localparam int P0 = (g % 4) * 2;
    localparam int P1 = P0 + 1;
    viterbi_acs u_acs (
      .pm0_i (pm_q[P0]),
      .pm1_i (pm_q[P1]),
      .bm0_i (bm0[g]),
      .bm1_i (bm1[g]),
      .pm_o  (acs_pm[g]),
      .dec_o (acs_dec[g])
    );
  end

`ifdef VITERBI_NORM_EN
  metric_t min_new;

  // Rebase all new metrics on the smallest so 6 bits never overflow.
  always_comb begin
    min_new = acs_pm[0];
    for (int i = 1; i < NUM_STATES; i++) begin
      if (acs_pm[i] < min_new) begin
        min_new = acs_pm[i];
      end
    end
    for (int i = 0; i < NUM_STATES; i++) begin
      pm_d[i] = acs_pm[i] - min_new;
    end
  end
`else
  // Metrics are wide enough that saturation in the adders suffices.
  always_comb begin
    for (int i = 0; i < NUM_STATES; i++) begin
      pm_d[i] = acs_pm[i];
    end
  end
`endif

  // Register exchange: copy the winning predecessor's path and append u.
  always_comb begin
    for (int i = 0; i < NUM_STATES; i++) begin
      state_t ns;
      state_t sel;
      ns        = state_t'(i);
      sel       = {ns[1:0], acs_dec[i]};
      path_d[i] = {path_q[sel][TB_DEPTH-2:0], ns[2]};
    end
  end

  // Accepted-symbol counter, saturating once the pipeline is full.
  always_comb begin
    cnt_d = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
  end

  // Metric, survivor and counter state; reset wins over seqrdy.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : metric_t'(PM_INIT);
        path_q[i] <= '0;
      end
      cnt_q <= '0;
    end else if (seqrdy) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_q[i]   <= pm_d[i];
        path_q[i] <= path_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

  // Best state from registered metrics; lowest index wins a tie.
  always_comb begin
    metric_t best;
    best      = pm_q[0];
    min_state = '0;
    for (int i = 1; i < NUM_STATES; i++) begin
      if (pm_q[i] < best) begin
        best      = pm_q[i];
        min_state = state_t'(i);
      end
    end
  end

  // Outputs come straight from registered state.
  always_comb begin
    Dx  = path_q[min_state][TB_DEPTH-1];
    oen = (cnt_q == 4'd15);
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Testbench for viterbi_decoder: directed streams (all-zero, impulse,
// single error, stall, mid-stream reset, tie-break) plus randomised noisy
// streams, scored against a full-history Viterbi model kept here.
module tb_viterbi_decoder;

  // ---------------- clock / reset / DUT ----------------
  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] Rx;
  logic       seqrdy;
  logic       Dx;
  logic       oen;

  always #5 clock = ~clock;

  viterbi_decoder dut (
    .clock  (clock),
    .reset  (reset),
    .Rx     (Rx),
    .seqrdy (seqrdy),
    .Dx     (Dx),
    .oen    (oen)
  );

  int total = 0;
  int bad   = 0;

  // Entry: {oen, Dx, min_state[2:0]} expected after an accepted symbol.
  logic [4:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Integer metrics without clamping, complete decision history per state;
  // the decoded bit is read 14 symbols back along the best state's history.
  int m_pm[8];
  bit m_path[8][$];
  int m_cnt;
  int enc_s;

  function automatic int parity(input int v);
    int p;
    p = 0;
    for (int b = 0; b < 4; b++) p ^= (v >> b) & 1;
    return p;
  endfunction

  // {c0,c1} as an integer 0..3 for input u leaving encoder state s.
  function automatic int code_of(input int u, input int s);
    int r;
    r = u * 8 + s;
    return parity(r & 15) * 2 + parity(r & 13);
  endfunction

  function automatic int ham(input int a, input int b);
    int x;
    x = a ^ b;
    return (x & 1) + ((x >> 1) & 1);
  endfunction

  function automatic int model_min();
    int mn;
    mn = 0;
    for (int i = 1; i < 8; i++) if (m_pm[i] < m_pm[mn]) mn = i;
    return mn;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_pm[i] = (i == 0) ? 0 : 16;
      m_path[i].delete();
    end
    m_cnt = 0;
  endtask

  task automatic model_step(input logic [1:0] rx);
    int npm[8];
    bit npath[8][$];
    int mn;
    int len;
    bit dx;
    bit ov;
    for (int ns = 0; ns < 8; ns++) begin
      int u, p0, p1, c0, c1, sel;
      u   = ns / 4;
      p0  = (ns % 4) * 2;
      p1  = p0 + 1;
      c0  = m_pm[p0] + ham(int'(rx), code_of(u, p0));
      c1  = m_pm[p1] + ham(int'(rx), code_of(u, p1));
      sel = (c1 < c0) ? p1 : p0;
      npm[ns]   = (c1 < c0) ? c1 : c0;
      npath[ns] = m_path[sel];
      npath[ns].push_back(bit'(u));
    end
    for (int i = 0; i < 8; i++) begin
      m_pm[i]   = npm[i];
      m_path[i] = npath[i];
    end
    if (m_cnt < 15) m_cnt++;
    mn  = model_min();
    len = m_path[mn].size();
    dx  = (len >= 15) ? m_path[mn][len-15] : 1'b0;
    ov  = (m_cnt == 15);
    exp_q.push_back({ov, dx, 3'(mn)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input bit rdy);
    reset  = 1'b1;
    seqrdy = rdy;
    Rx     = 2'($urandom_range(0, 3));
    model_reset();
    enc_s  = 0;
    @(posedge clock);
    #1;
    reset  = 1'b0;
    seqrdy = 1'b0;
  endtask

  task automatic send(input logic [1:0] rx);
    Rx     = rx;
    seqrdy = 1'b1;
    model_step(rx);
    @(posedge clock);
    #1;
    seqrdy = 1'b0;
  endtask

  task automatic idle(input int n);
    seqrdy = 1'b0;
    repeat (n) begin
      Rx = 2'($urandom_range(0, 3));
      @(posedge clock);
      #1;
    end
  endtask

  // Encode bit u from the bench's own encoder, optionally XOR an error.
  task automatic send_bit(input int u, input int err);
    int c;
    c     = code_of(u, enc_s);
    enc_s = (u << 2) | (enc_s >> 1);
    send(2'(c ^ err));
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit acc_edge = 1'b0;
  bit rst_edge = 1'b0;
  bit last_oen = 1'b0;
  bit last_dx  = 1'b0;

  always @(posedge clock) begin
    acc_edge = seqrdy && !reset;
    rst_edge = reset;
  end

  always @(negedge clock) begin
    if (rst_edge) begin
      check("reset_oen", int'(oen), 0);
      check("reset_dx", int'(Dx), 0);
      check("reset_min_state", int'(dut.min_state), 0);
    end else if (acc_edge) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check("oen", int'(oen), int'(e[4]));
        check("dx", int'(Dx), int'(e[3]));
        check("min_state", int'(dut.min_state), int'(e[2:0]));
      end
    end else begin
      check("frozen_oen", int'(oen), int'(last_oen));
      check("frozen_dx", int'(Dx), int'(last_dx));
    end
    last_oen = oen;
    last_dx  = Dx;
  end

  // ---------------- stimulus ----------------
  int impulse[30];
  int off;

  initial begin
    reset  = 1'b1;
    seqrdy = 1'b0;
    Rx     = 2'b00;
    model_reset();
    enc_s  = 0;
    for (int i = 0; i < 30; i++) impulse[i] = (i == 0) ? 1 : 0;

    do_reset(1'b0);

    // Tie-break: one Rx=01 gives PM[0]=PM[4]=1, min_state stays 0.
    send(2'b01);
    off = 0;
`ifdef VITERBI_NORM_EN
    off = m_pm[model_min()];
`endif
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pm[%0d]", i), int'(dut.pm_q[i]), m_pm[i] - off);
    end
    check("tie_pm0", m_pm[0], 1);
    check("tie_pm4", m_pm[4], 1);

    // All-zero stream.
    do_reset(1'b0);
    for (int i = 0; i < 30; i++) send_bit(0, 0);

    // Impulse.
    do_reset(1'b0);
    for (int i = 0; i < 30; i++) send_bit(impulse[i], 0);

    // Impulse with the third symbol forced to 00 (encoded 10 -> flip 2'b10).
    do_reset(1'b0);
    for (int i = 0; i < 30; i++) send_bit(impulse[i], (i == 2) ? 2 : 0);

    // Impulse with a five-cycle stall between symbols 7 and 8.
    do_reset(1'b0);
    for (int i = 0; i < 30; i++) begin
      if (i == 8) idle(5);
      send_bit(impulse[i], 0);
    end

    // Twenty all-ones symbols, reset with seqrdy high, then a fresh stream.
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) send_bit(1, 0);
    do_reset(1'b1);
    for (int i = 0; i < 20; i++) send_bit(int'($urandom_range(0, 1)), 0);

    // Random data, sparse channel errors, random stalls.
    do_reset(1'b0);
    for (int i = 0; i < 300; i++) begin
      int err;
      if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(1, 3)));
      err = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 3)) : 0;
      send_bit(int'($urandom_range(0, 1)), err);
    end

    // Pure noise on Rx exercises arbitrary metric spreads.
    do_reset(1'b0);
    for (int i = 0; i < 120; i++) send(2'($urandom_range(0, 3)));

    idle(3);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
